// File: rtl/iir_decim_out.sv
// Decimating output stage for the Q20 IIR: keeps every DECIM-th sample, shifts and
// saturates it to OUT_W bits, and queues it in a small FIFO drained over valid/ready.
module iir_decim_out #(
    parameter int DECIM = 16,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [31:0]              y_in,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic                     ovf_flag,
    input  logic                     flag_clr
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

    // Shift then clip; MSB of the result is the clip indication.
    function automatic logic [OUT_W:0] sat_shift(input logic [31:0] y);
        logic signed [31:0] v;
        logic signed [32:0] vx;
        v  = $signed(y) >>> SHIFT;
        vx = {v[31], v};
        if (vx > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (vx < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            return {1'b0, v[OUT_W-1:0]};
        end
    endfunction

    logic [CW-1:0]    cnt_r;
    logic [OUT_W-1:0] stage_d_r;
    logic             stage_v_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [OUT_W-1:0] m_data_r;
    logic             m_valid_r;
    logic             sat_flag_r;
    logic             ovf_flag_r;
    logic [OUT_W-1:0] mem_r [DEPTH];

    logic             capture_s;
    logic [OUT_W:0]   sat_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [AW-1:0]    rd_nxt_s;
    logic [LW-1:0]    lvl_nxt_s;
    logic [OUT_W-1:0] head_nxt_s;

    assign capture_s = en && (cnt_r == CNT_LAST);
    assign sat_s     = sat_shift(y_in);

    // Decimation phase counter; en low freezes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CW'(0);
        end else if (en) begin
            cnt_r <= (cnt_r == CNT_LAST) ? CW'(0) : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Capture register holding the shifted, saturated kept sample for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_d_r <= OUT_W'(0);
            stage_v_r <= 1'b0;
        end else if (capture_s) begin
            stage_d_r <= sat_s[OUT_W-1:0];
            stage_v_r <= 1'b1;
        end else begin
            stage_v_r <= 1'b0;
        end
    end

    // FIFO control plus the next head, so m_data can be registered yet track rd_ptr.
    always_comb begin
        pop_s      = m_valid_r && m_ready;
        push_s     = 1'b0;
        drop_s     = 1'b0;
        rd_nxt_s   = rd_ptr_r + AW'(pop_s);
        lvl_nxt_s  = level_r;
        head_nxt_s = mem_r[rd_nxt_s];
        if (stage_v_r) begin
            push_s = (level_r != LVL_FULL) || pop_s;
            drop_s = !push_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   lvl_nxt_s = level_r + LW'(1);
            2'b01:   lvl_nxt_s = level_r - LW'(1);
            default: lvl_nxt_s = level_r;
        endcase
        // A write landing on the slot that becomes the head bypasses the memory read.
        if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = stage_d_r;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Storage array: contents need no reset, occupancy is tracked by level.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= stage_d_r;
        end
    end

    // Pointers, occupancy and registered output view of the FIFO head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= AW'(0);
            rd_ptr_r  <= AW'(0);
            level_r   <= LW'(0);
            m_data_r  <= OUT_W'(0);
            m_valid_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_r + AW'(push_s);
            rd_ptr_r  <= rd_nxt_s;
            level_r   <= lvl_nxt_s;
            m_valid_r <= (lvl_nxt_s != LW'(0));
            m_data_r  <= (lvl_nxt_s != LW'(0)) ? head_nxt_s : OUT_W'(0);
        end
    end

    // Sticky flags; a set event on the same edge as flag_clr takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag_r <= 1'b0;
            ovf_flag_r <= 1'b0;
        end else begin
            sat_flag_r <= (capture_s && sat_s[OUT_W]) ? 1'b1 : (flag_clr ? 1'b0 : sat_flag_r);
            ovf_flag_r <= drop_s ? 1'b1 : (flag_clr ? 1'b0 : ovf_flag_r);
        end
    end

    assign m_data   = m_data_r;
    assign m_valid  = m_valid_r;
    assign level    = level_r;
    assign sat_flag = sat_flag_r;
    assign ovf_flag = ovf_flag_r;

endmodule

// File: tb/tb_iir_decim_out.sv
// Directed bench for iir_decim_out at default parameters (DECIM=16, SHIFT=8, OUT_W=16, DEPTH=8).
module tb_iir_decim_out;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] y_in;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  level;
    logic        sat_flag;
    logic        ovf_flag;
    logic        flag_clr;

    int n_pass;
    int n_total;

    iir_decim_out #(.DECIM(16), .SHIFT(8), .OUT_W(16), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .y_in     (y_in),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag),
        .flag_clr (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Two-cycle reset; edge numbering restarts at 1 on the next tick.
    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; y_in = 32'h0; m_ready = 1'b0; flag_clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", m_valid); else n_pass++;
        n_total++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_total++; if ({sat_flag, ovf_flag} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {sat_flag, ovf_flag}); else n_pass++;
        n_total++; if (m_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", m_data); else n_pass++;
        rst = 1'b1; en = 1'b1; y_in = 32'h0000_1234; m_ready = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            tick();
            if (t == 16 || t == 18 || t == 32) begin
                n_total++; if (m_valid !== 1'b0) $display("FAIL first_idle_t%0d: got %0h want 0", t, m_valid); else n_pass++;
            end
            if (t == 17 || t == 33) begin
                n_total++; if (m_valid !== 1'b1) $display("FAIL first_valid_t%0d: got %0h want 1", t, m_valid); else n_pass++;
                n_total++; if (m_data !== 16'h0012) $display("FAIL first_data_t%0d: got %h want 0012", t, m_data); else n_pass++;
            end
        end
    endtask

    task automatic test_saturation;
        do_reset();
        en = 1'b1; m_ready = 1'b1; y_in = 32'h7FFF_FFFF;
        for (int t = 1; t <= 34; t++) begin
            if (t == 34) flag_clr = 1'b1;
            tick();
            flag_clr = 1'b0;
            if (t == 16) begin
                n_total++; if (sat_flag !== 1'b1) $display("FAIL sat_set: got %0h want 1", sat_flag); else n_pass++;
            end
            if (t == 17) begin
                n_total++; if (m_data !== 16'h7FFF) $display("FAIL sat_pos: got %h want 7fff", m_data); else n_pass++;
                y_in = 32'h8000_0000;
            end
            if (t == 33) begin
                n_total++; if (m_data !== 16'h8000 || m_valid !== 1'b1) $display("FAIL sat_neg: got %h/%0h want 8000/1", m_data, m_valid); else n_pass++;
            end
            if (t == 34) begin
                n_total++; if (sat_flag !== 1'b0) $display("FAIL sat_clr: got %0h want 0", sat_flag); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        en = 1'b1; m_ready = 1'b0;
        for (int p = 0; p < 9; p++) begin
            y_in = 32'(p) << 8;
            for (int k = 0; k < 16; k++) tick();
        end
        n_total++; if (level !== 4'd8 || ovf_flag !== 1'b0) $display("FAIL bp_full: got lvl %0d ovf %0h want 8/0", level, ovf_flag); else n_pass++;
        tick();
        n_total++; if (ovf_flag !== 1'b1 || level !== 4'd8) $display("FAIL bp_drop: got ovf %0h lvl %0d want 1/8", ovf_flag, level); else n_pass++;
        tick();
        n_total++; if (m_data !== 16'h0 || m_valid !== 1'b1) $display("FAIL bp_hold: got %h/%0h want 0000/1", m_data, m_valid); else n_pass++;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (m_data !== 16'(i) || m_valid !== 1'b1) $display("FAIL bp_drain%0d: got %h/%0h want %h/1", i, m_data, m_valid, 16'(i)); else n_pass++;
            tick();
        end
        n_total++; if (level !== 4'd0 || m_valid !== 1'b0) $display("FAIL bp_empty: got lvl %0d valid %0h want 0/0", level, m_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        en = 1'b1; m_ready = 1'b0;
        for (int p = 0; p < 9; p++) begin
            y_in = 32'(p) << 8;
            for (int k = 0; k < 16; k++) tick();
        end
        m_ready = 1'b1;
        tick();
        n_total++; if (level !== 4'd8 || ovf_flag !== 1'b0) $display("FAIL b2b_level: got lvl %0d ovf %0h want 8/0", level, ovf_flag); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_total++; if (m_data !== 16'(i)) $display("FAIL b2b_drain%0d: got %h want %h", i, m_data, 16'(i)); else n_pass++;
            tick();
        end
        n_total++; if (level !== 4'd0) $display("FAIL b2b_empty: got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_en_gating;
        do_reset();
        m_ready = 1'b1; y_in = 32'hFFFF_F000;
        for (int t = 1; t <= 64; t++) begin
            en = (t % 2 == 1);
            tick();
            if (t == 31 || t == 63) begin
                n_total++; if (m_valid !== 1'b0) $display("FAIL en_idle_t%0d: got %0h want 0", t, m_valid); else n_pass++;
            end
            if (t == 32) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== 16'hFFF0) $display("FAIL en_cap1: got %0h/%h want 1/fff0", m_valid, m_data); else n_pass++;
                y_in = 32'h0005_0000;
            end
            if (t == 64) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== 16'h0500) $display("FAIL en_cap2: got %0h/%h want 1/0500", m_valid, m_data); else n_pass++;
                m_ready = 1'b0;
                en = 1'b0;
            end
        end
        for (int i = 0; i < 5; i++) tick();
        n_total++; if (m_valid !== 1'b1 || m_data !== 16'h0500) $display("FAIL en_stall: got %0h/%h want 1/0500", m_valid, m_data); else n_pass++;
        m_ready = 1'b1;
        tick();
        n_total++; if (m_valid !== 1'b0 || level !== 4'd0) $display("FAIL en_drain: got %0h/%0d want 0/0", m_valid, level); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        en = 1'b1; m_ready = 1'b0; y_in = 32'h0000_0300;
        for (int t = 1; t <= 96; t++) tick();
        n_total++; if (level !== 4'd5) $display("FAIL mid_pre_level: got %0d want 5", level); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (level !== 4'd0 || m_valid !== 1'b0) $display("FAIL mid_async: got %0d/%0h want 0/0", level, m_valid); else n_pass++;
        tick();
        n_total++; if (level !== 4'd0 || m_valid !== 1'b0 || m_data !== 16'h0) $display("FAIL mid_held: got %0d/%0h/%h want 0/0/0000", level, m_valid, m_data); else n_pass++;
        rst = 1'b1; m_ready = 1'b1; y_in = 32'h0000_0700;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t == 1) begin
                n_total++; if (m_valid !== 1'b0) $display("FAIL mid_stage_lost: got %0h want 0", m_valid); else n_pass++;
            end
            if (t == 16) begin
                n_total++; if (m_valid !== 1'b0) $display("FAIL mid_early: got %0h want 0", m_valid); else n_pass++;
            end
            if (t == 17) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== 16'h0007) $display("FAIL mid_first: got %0h/%h want 1/0007", m_valid, m_data); else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_en_gating();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
